// File: rtl/cache_assoc2_wb.sv
// ---------------------------------------------------------------------------
// cache_assoc2_wb
//   Two-way set-associative, write-back, write-allocate data cache with one
//   LRU bit per set. Misses stall the CPU while a small FSM writes back a
//   dirty victim (if needed) and refills the line over a line-wide
//   request/acknowledge port. Memory latency may be any number of cycles.
//
//   Address layout (word address): {tag, set, word}.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   address       word address of the CPU request
//   d_in          store data
//   write_enable  store request (wins if read_en is also set)
//   read_en       load request
//   d_out         load data, valid when read_en && !stall, else 0
//   stall         request not completed this cycle; CPU holds its inputs
//   mem_req       memory transaction pending (registered)
//   mem_we        1 = line write-back, 0 = line refill (registered)
//   mem_addr      line address of the transaction (registered)
//   mem_wdata     victim line being written back
//   mem_rdata     refill line, sampled when mem_ack = 1
//   mem_ack       memory completes the transaction this cycle
//
// Optional feature (macro CACHE_PERF_EN):
//   hit_count, miss_count, wb_count  32-bit wrapping event counters.
//
// Handshake: a transaction is offered while mem_req = 1 and completes on
// the rising edge where mem_ack = 1. mem_ack with mem_req = 0 is ignored.
// ---------------------------------------------------------------------------
module cache_assoc2_wb #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int SET_BITS      = 5,
  parameter int BLOCK_SIZE    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ADDRESS_WIDTH-1:0]              address,
  input  logic [DATA_WIDTH-1:0]                 d_in,
  input  logic                                  write_enable,
  input  logic                                  read_en,
  output logic [DATA_WIDTH-1:0]                 d_out,
  output logic                                  stall,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDRESS_WIDTH-BLOCK_SIZE-1:0]   mem_addr,
  output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] mem_wdata,
  input  logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] mem_rdata,
  input  logic                                  mem_ack
`ifdef CACHE_PERF_EN
  ,
  output logic [31:0]                           hit_count,
  output logic [31:0]                           miss_count,
  output logic [31:0]                           wb_count
`endif
);

  localparam int NUM_SETS = 1 << SET_BITS;
  localparam int LINE_W   = DATA_WIDTH * (1 << BLOCK_SIZE);
  localparam int TAG_W    = ADDRESS_WIDTH - SET_BITS - BLOCK_SIZE;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  state_t state;

  // Per-way storage. Lines and tags are not reset; valid/dirty/lru are.
  logic [LINE_W-1:0]   line_mem [2][NUM_SETS];
  logic [TAG_W-1:0]    tag_mem  [2][NUM_SETS];
  logic [NUM_SETS-1:0] valid    [2];
  logic [NUM_SETS-1:0] dirty    [2];
  logic [NUM_SETS-1:0] lru;       // index of the least-recently-used way
  logic                victim_r;  // way chosen at miss detect, held for the miss

  logic [BLOCK_SIZE-1:0] req_word;
  logic [SET_BITS-1:0]   req_set;
  logic [TAG_W-1:0]      req_tag;

  assign req_word = address[BLOCK_SIZE-1:0];
  assign req_set  = address[BLOCK_SIZE +: SET_BITS];
  assign req_tag  = address[ADDRESS_WIDTH-1 -: TAG_W];

  logic access, hit0, hit1, hit, hit_way;
  logic victim_sel, victim_dirty;
  logic idle, load_hit, miss;
  logic [LINE_W-1:0] hit_line;

  assign access  = write_enable | read_en;
  assign hit0    = valid[0][req_set] && (tag_mem[0][req_set] == req_tag);
  assign hit1    = valid[1][req_set] && (tag_mem[1][req_set] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;

  // First invalid way (way0 preferred), otherwise the LRU way.
  assign victim_sel   = !valid[0][req_set] ? 1'b0 :
                        (!valid[1][req_set] ? 1'b1 : lru[req_set]);
  assign victim_dirty = valid[victim_sel][req_set] && dirty[victim_sel][req_set];

  assign idle     = (state == IDLE);
  assign load_hit = idle && read_en && !write_enable && hit;
  assign miss     = idle && access && !hit;
  assign hit_line = line_mem[hit_way][req_set];

  assign d_out     = load_hit ? hit_line[req_word*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign stall     = !idle || miss;
  // The CPU holds address during the miss, so req_set still names the set.
  assign mem_wdata = line_mem[victim_r][req_set];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      victim_r <= 1'b0;
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && hit) begin
            lru[req_set] <= ~hit_way;
            if (write_enable) begin
              line_mem[hit_way][req_set][req_word*DATA_WIDTH +: DATA_WIDTH] <= d_in;
              dirty[hit_way][req_set] <= 1'b1;
            end
          end else if (access) begin
            victim_r <= victim_sel;
            mem_req  <= 1'b1;
            if (victim_dirty) begin
              state    <= WRITEBACK;
              mem_we   <= 1'b1;
              mem_addr <= {tag_mem[victim_sel][req_set], req_set};
            end else begin
              state    <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_set};
            end
          end
        end
        WRITEBACK: begin
          // mem_req stays high; only direction and address change.
          if (mem_ack) begin
            state    <= REFILL;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_set};
          end
        end
        REFILL: begin
          if (mem_ack) begin
            state                     <= IDLE;
            mem_req                   <= 1'b0;
            line_mem[victim_r][req_set] <= mem_rdata;
            tag_mem[victim_r][req_set]  <= req_tag;
            valid[victim_r][req_set]    <= 1'b1;
            dirty[victim_r][req_set]    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_PERF_EN
  // retry_r marks the IDLE cycle right after a refill, whose hit is the
  // replay of the missed request and is not counted as a hit.
  logic retry_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_r    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      retry_r <= (state == REFILL) && mem_ack;
      if (idle && access && hit && !retry_r) hit_count <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
      if ((state == WRITEBACK) && mem_ack) wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule
